tag_decoder: RTL and testbench
==============================

Name: tag_decoder

Overview:
- Downstream stage of the compressor: reads the 6-bit winner tags from TAG RAM and the 64-entry codebook from W RAM, and rebuilds the image into OUT RAM, one 24-bit RGB pixel per cycle.
- Also reads the original image from IF RAM and accumulates the total Manhattan (sum-of-absolute-difference) distortion.
- Runs after the compressor asserts done; the compressor's done drives this block's start.

Parameters:
- PIX_AW, 18, pixel address width; image has NUM_PIX = 2**PIX_AW pixels.
- CB_SIZE, 64, codebook entries; index = {tag[5:3]=y, tag[2:0]=x}.
- ERR_W, PIX_AW+10, distortion accumulator width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run
- RAM_W_OE  out  1  codebook RAM read enable
- RAM_W_A  out  18  codebook address
- RAM_W_Q  in  24  codebook data
- RAM_TAG_OE  out  1  tag RAM read enable
- RAM_TAG_A  out  18  tag address
- RAM_TAG_Q  in  24  tag word; only [5:0] used
- RAM_IF_OE  out  1  original-image read enable
- RAM_IF_A  out  18  original pixel address
- RAM_IF_Q  in  24  original pixel {R,G,B}
- RAM_OUT_WE  out  1  reconstructed-image write enable
- RAM_OUT_A  out  18  write address
- RAM_OUT_D  out  24  reconstructed pixel
- sad_total  out  ERR_W  accumulated distortion; stable while done=1
- busy  out  1  run in progress
- done  out  1  run complete (level)

Behaviour:
- All RAMs are synchronous: Q is valid the cycle after A is presented with OE=1.
- Reset (rst=0, any time, including mid-run):
  - state goes to IDLE; codebook register file, counters and sad_total go to 0.
  - All OE/WE, busy and done go to 0; all addresses and data go to 0.
  - No partial write completes after reset is asserted.
- FSM states IDLE, LOAD_CB, DECODE, DRAIN, DONE:
  - IDLE: wait for start. On start: go to LOAD_CB, clear sad_total, set busy=1.
  - LOAD_CB: issue W addresses 0..63 with RAM_W_OE=1 (64 cycles). Each returned word is stored into cb[addr-1] the following cycle. Move to DECODE after the last address is issued; cb[63] is captured in the first DECODE cycle.
  - DECODE: each cycle issue pixel address p (0..NUM_PIX-1) to both TAG and IF with OE=1. At p = NUM_PIX-1, go to DRAIN.
  - DRAIN: one cycle to retire the last pixel, then DONE.
  - DONE: done=1, busy=0, all OE/WE=0. A new start returns to LOAD_CB (sad_total cleared, done drops the next cycle).
- Decode pipeline, 1 pixel/cycle, write latency 1:
  - In the cycle after issuing p: RAM_OUT_WE=1, RAM_OUT_A=p, RAM_OUT_D=cb[RAM_TAG_Q[5:0]].
  - In the same cycle: sad_total += |R-R'| + |G-G'| + |B-B'|, using 8-bit unsigned channels (per-pixel max 765).
- Accumulator: ERR_W bits, cannot overflow for 765*NUM_PIX; no saturation logic.
- Tag bits [23:6] are ignored.
- start while busy=1 is ignored.
- Run length from start to done=1: 1 (IDLE→LOAD_CB) + 64 + NUM_PIX + 1 cycles.
- Write and W addresses are zero-extended to 18 bits.

Decomposition:
- Shared package: state encodings, CB_SIZE, channel width 8, tag field positions (x=[2:0], y=[5:3]).
- One sub-module, pixel_sad: combinational 24-bit |a-b| summed over three channels, 10-bit result, reused by the tag-RAM writer's checker.

Test Plan (PIX_AW=4, 16 pixels):
- Reset mid-DECODE at pixel 7: RAM_OUT_WE drops immediately; busy=0, done=0, sad_total=0. A following start reruns from address 0.
- Codebook cb[i]={i,i,i}, tags = pixel index, IF = {p,p,p}: OUT[p]={p,p,p}, sad_total=0, done asserted 82 cycles after start.
- Same codebook, all tags 6'd63 with [23:6]=all ones, IF=0: every OUT=24'h3F3F3F, sad_total = 16*189 = 3024.
- Extreme values: cb[0]=24'hFFFFFF, tags=0, IF=0 → sad_total = 16*765 = 12240. Repeat with PIX_AW=18 → sad_total = 200540160, no wrap.
- start pulsed while busy → ignored, output identical. start pulsed in DONE → second run produces an identical sad_total, and done is low for exactly one run.

Source files
------------

// File: rtl/tag_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tag_decoder_pkg
// Brief   : Shared constants, state encodings and helpers for the tag decoder.
// Revision: 1.0
// ============================================================================
package tag_decoder_pkg;

    localparam int CB_SIZE   = 64;
    localparam int CB_AW     = 6;
    localparam int CH_W      = 8;
    localparam int NUM_CH    = 3;
    localparam int PIX_W     = NUM_CH * CH_W;
    localparam int SAD_W     = 10;
    localparam int RAM_AW    = 18;

    // Codebook index is {y, x}; each field is three bits of the tag word.
    localparam int TAG_FW    = 3;
    localparam int TAG_X_LSB = 0;
    localparam int TAG_Y_LSB = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD_CB = 3'd1;
    localparam state_t ST_DECODE  = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tag_decoder_pixel_sad.sv
`default_nettype none
// ============================================================================
// Module  : tag_decoder_pixel_sad
// Brief   : Combinational Manhattan distance between two RGB pixels.
// Revision: 1.0
// ============================================================================
module tag_decoder_pixel_sad
    import tag_decoder_pkg::*;
(
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [SAD_W-1:0] sad_o
);

    logic [CH_W-1:0] diff [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign diff[c] = abs_diff(a_i[c*CH_W +: CH_W], b_i[c*CH_W +: CH_W]);
    end

    // 3 * 255 = 765 fits in the 10-bit result.
    assign sad_o = SAD_W'(diff[0]) + SAD_W'(diff[1]) + SAD_W'(diff[2]);

endmodule
`default_nettype wire

// File: rtl/tag_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tag_decoder
// Brief   : Rebuilds the image from winner tags and codebook, accumulating SAD.
// Revision: 1.0
// ============================================================================
module tag_decoder
    import tag_decoder_pkg::*;
#(
    parameter int PIX_AW = 18,
    parameter int ERR_W  = PIX_AW + 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                RAM_W_OE,
    output logic [RAM_AW-1:0]   RAM_W_A,
    input  logic [PIX_W-1:0]    RAM_W_Q,
    output logic                RAM_TAG_OE,
    output logic [RAM_AW-1:0]   RAM_TAG_A,
    input  logic [PIX_W-1:0]    RAM_TAG_Q,
    output logic                RAM_IF_OE,
    output logic [RAM_AW-1:0]   RAM_IF_A,
    input  logic [PIX_W-1:0]    RAM_IF_Q,
    output logic                RAM_OUT_WE,
    output logic [RAM_AW-1:0]   RAM_OUT_A,
    output logic [PIX_W-1:0]    RAM_OUT_D,
    output logic [ERR_W-1:0]    sad_total,
    output logic                busy,
    output logic                done
);

    localparam int NUM_PIX = 2 ** PIX_AW;
    localparam int CNT_W   = (PIX_AW > CB_AW) ? PIX_AW : CB_AW;
    localparam logic [CNT_W-1:0] CNT_CB_LAST  = CNT_W'(CB_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_PIX_LAST = CNT_W'(NUM_PIX - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_ok;

    logic               cb_wr_q;
    logic [CB_AW-1:0]   cb_idx_q;
    logic [PIX_W-1:0]   cb_q [CB_SIZE];

    logic               out_vld_q;
    logic [PIX_AW-1:0]  out_addr_q;
    logic [ERR_W-1:0]   sad_q;

    logic [CB_AW-1:0]   tag_idx;
    logic [PIX_W-1:0]   recon;
    logic [SAD_W-1:0]   pix_sad;
    logic               unused_tag_hi;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD_CB;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_CB: begin
                if (cnt_q == CNT_CB_LAST) begin
                    state_d = ST_DECODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (cnt_q == CNT_PIX_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        RAM_W_OE   = 1'b0;
        RAM_W_A    = '0;
        RAM_TAG_OE = 1'b0;
        RAM_TAG_A  = '0;
        RAM_IF_OE  = 1'b0;
        RAM_IF_A   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_LOAD_CB: begin
                busy     = 1'b1;
                RAM_W_OE = 1'b1;
                RAM_W_A  = RAM_AW'(cnt_q[CB_AW-1:0]);
            end
            ST_DECODE: begin
                busy       = 1'b1;
                RAM_TAG_OE = 1'b1;
                RAM_TAG_A  = RAM_AW'(cnt_q[PIX_AW-1:0]);
                RAM_IF_OE  = 1'b1;
                RAM_IF_A   = RAM_AW'(cnt_q[PIX_AW-1:0]);
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // RAM data returns one cycle after the address; these registers remember
    // which codebook slot / output pixel the returning word belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cb_wr_q    <= 1'b0;
            cb_idx_q   <= '0;
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            sad_q      <= '0;
            for (int i = 0; i < CB_SIZE; i++) begin
                cb_q[i] <= '0;
            end
        end else begin
            cb_wr_q    <= (state_q == ST_LOAD_CB);
            cb_idx_q   <= cnt_q[CB_AW-1:0];
            out_vld_q  <= (state_q == ST_DECODE);
            out_addr_q <= cnt_q[PIX_AW-1:0];
            if (cb_wr_q) begin
                cb_q[cb_idx_q] <= RAM_W_Q;
            end
            if (start_ok) begin
                sad_q <= '0;
            end else if (out_vld_q) begin
                sad_q <= sad_q + ERR_W'(pix_sad);
            end
        end
    end

    assign tag_idx       = {RAM_TAG_Q[TAG_Y_LSB +: TAG_FW], RAM_TAG_Q[TAG_X_LSB +: TAG_FW]};
    assign recon         = cb_q[tag_idx];
    assign unused_tag_hi = ^RAM_TAG_Q[PIX_W-1:CB_AW];

    tag_decoder_pixel_sad u_pixel_sad (
        .a_i   (recon),
        .b_i   (RAM_IF_Q),
        .sad_o (pix_sad)
    );

    assign RAM_OUT_WE = out_vld_q;
    assign RAM_OUT_A  = out_vld_q ? RAM_AW'(out_addr_q) : '0;
    assign RAM_OUT_D  = out_vld_q ? recon : '0;
    assign sad_total  = sad_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tag_decoder
// Brief   : Self-checking bench for tag_decoder with 16-pixel image.
// Revision: 1.0
// ============================================================================
module tb_tag_decoder;

    localparam int PIX_AW    = 4;
    localparam int NUM_PIX   = 1 << PIX_AW;
    localparam int ERR_W     = PIX_AW + 10;
    localparam int RUN_EDGES = 1 + 64 + NUM_PIX + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              RAM_W_OE;
    logic [17:0]       RAM_W_A;
    logic [23:0]       RAM_W_Q;
    logic              RAM_TAG_OE;
    logic [17:0]       RAM_TAG_A;
    logic [23:0]       RAM_TAG_Q;
    logic              RAM_IF_OE;
    logic [17:0]       RAM_IF_A;
    logic [23:0]       RAM_IF_Q;
    logic              RAM_OUT_WE;
    logic [17:0]       RAM_OUT_A;
    logic [23:0]       RAM_OUT_D;
    logic [ERR_W-1:0]  sad_total;
    logic              busy;
    logic              done;

    logic [23:0] w_mem   [64];
    logic [23:0] tag_mem [NUM_PIX];
    logic [23:0] if_mem  [NUM_PIX];
    logic [23:0] out_mem [NUM_PIX];

    int tests = 0;
    int fails = 0;

    tag_decoder #(.PIX_AW(PIX_AW), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .RAM_W_OE   (RAM_W_OE),
        .RAM_W_A    (RAM_W_A),
        .RAM_W_Q    (RAM_W_Q),
        .RAM_TAG_OE (RAM_TAG_OE),
        .RAM_TAG_A  (RAM_TAG_A),
        .RAM_TAG_Q  (RAM_TAG_Q),
        .RAM_IF_OE  (RAM_IF_OE),
        .RAM_IF_A   (RAM_IF_A),
        .RAM_IF_Q   (RAM_IF_Q),
        .RAM_OUT_WE (RAM_OUT_WE),
        .RAM_OUT_A  (RAM_OUT_A),
        .RAM_OUT_D  (RAM_OUT_D),
        .sad_total  (sad_total),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models.
    always @(posedge clk) begin
        if (RAM_W_OE)   RAM_W_Q   <= w_mem[RAM_W_A[5:0]];
        if (RAM_TAG_OE) RAM_TAG_Q <= tag_mem[RAM_TAG_A[PIX_AW-1:0]];
        if (RAM_IF_OE)  RAM_IF_Q  <= if_mem[RAM_IF_A[PIX_AW-1:0]];
        if (RAM_OUT_WE) out_mem[RAM_OUT_A[PIX_AW-1:0]] <= RAM_OUT_D;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int p);
        logic [23:0] t;
        t = tag_mem[p];
        return w_mem[t[5:0]];
    endfunction

    function automatic int model_sad();
        int s = 0;
        for (int p = 0; p < NUM_PIX; p++) begin
            logic [23:0] r;
            logic [23:0] o;
            r = model_pix(p);
            o = if_mem[p];
            for (int c = 0; c < 3; c++) begin
                int a = int'(r[8*c +: 8]);
                int b = int'(o[8*c +: 8]);
                s += (a > b) ? (a - b) : (b - a);
            end
        end
        return s;
    endfunction

    // Scoreboard: every write must land in order with the model pixel,
    // and the final total must match the model sum.
    initial begin
        int   wr_idx;
        logic busy_prev;
        logic done_prev;
        wr_idx    = 0;
        busy_prev = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_idx = 0;
            end else begin
                if (busy && !busy_prev) wr_idx = 0;
                if (RAM_OUT_WE) begin
                    check("wr_addr", 32'(RAM_OUT_A), 32'(wr_idx));
                    check("wr_data", 32'(RAM_OUT_D), 32'(model_pix(wr_idx)));
                    wr_idx++;
                end
                if (done && !done_prev) begin
                    check("wr_count", 32'(wr_idx), 32'(NUM_PIX));
                    check("sad_model", 32'(sad_total), 32'(model_sad()));
                end
            end
            busy_prev = busy;
            done_prev = done;
        end
    end

    task automatic load_base(input int mode);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'(i);
            w_mem[i] = {b, b, b};
        end
        for (int p = 0; p < NUM_PIX; p++) begin
            logic [7:0] b;
            b = 8'(p);
            case (mode)
                0: begin tag_mem[p] = 24'(p);       if_mem[p] = {b, b, b}; end
                1: begin tag_mem[p] = 24'hFFFFFF;   if_mem[p] = 24'h0;     end
                default: begin tag_mem[p] = 24'h0;  if_mem[p] = 24'h0;     end
            endcase
            out_mem[p] = 24'h0;
        end
        if (mode == 2) w_mem[0] = 24'hFFFFFF;
    endtask

    // Pulse start and count rising edges (start edge included) until done.
    task automatic do_run(input bit glitch, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start = 1'b0;
        check("first_w_addr", {13'd0, RAM_W_OE, RAM_W_A}, {13'd0, 1'b1, 18'd0});
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            start = glitch && (edges == 40 || edges == 70);
        end
        start = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int   edges;
        logic found;
        rst   = 1'b0;
        start = 1'b0;
        load_base(0);
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_sad",   32'(sad_total), 32'd0);
        check("rst_oe_we", {29'd0, RAM_W_OE, RAM_TAG_OE, RAM_OUT_WE}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Identity codebook and tags: zero distortion.
        do_run(1'b0, edges);
        check("runlen_A", 32'(edges), 32'(RUN_EDGES));
        check("runlen_A_lit", 32'(edges), 32'd82);
        check("sad_A", 32'(sad_total), 32'd0);
        check("out_A5", 32'(out_mem[5]), 32'h050505);
        check("out_A15", 32'(out_mem[15]), 32'h0F0F0F);
        check("busy_done_A", {30'd0, busy, done}, 32'd1);

        // Tag 63 with junk upper bits; abort at pixel 7, then rerun.
        load_base(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (RAM_TAG_OE && RAM_TAG_A == 18'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_pix7", {31'd0, found}, 32'd1);
        check("pre_rst_we", {31'd0, RAM_OUT_WE}, 32'd1);
        check("pre_rst_sad", 32'(sad_total), 32'd1134);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_we",   {31'd0, RAM_OUT_WE}, 32'd0);
        check("mid_rst_flags", {30'd0, busy, done}, 32'd0);
        check("mid_rst_sad",  32'(sad_total), 32'd0);
        check("mid_rst_tag",  {13'd0, RAM_TAG_OE, RAM_TAG_A}, 32'd0);
        repeat (2) @(negedge clk);
        check("no_partial_wr", 32'(out_mem[6]), 32'd0);
        check("pre_abort_wr",  32'(out_mem[5]), 32'h3F3F3F);
        rst = 1'b1;
        do_run(1'b0, edges);
        check("runlen_B", 32'(edges), 32'd82);
        check("sad_B", 32'(sad_total), 32'd3024);
        check("out_B0", 32'(out_mem[0]), 32'h3F3F3F);
        check("out_B11", 32'(out_mem[11]), 32'h3F3F3F);

        // Extreme values with stray starts while busy.
        load_base(2);
        do_run(1'b1, edges);
        check("runlen_C", 32'(edges), 32'd82);
        check("sad_C", 32'(sad_total), 32'd12240);
        check("out_C3", 32'(out_mem[3]), 32'hFFFFFF);
        check("done_C", {31'd0, done}, 32'd1);

        // Restart from DONE.
        do_run(1'b0, edges);
        check("runlen_D", 32'(edges), 32'd82);
        check("sad_D", 32'(sad_total), 32'd12240);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
